// File: rtl/seg7_display_controller.sv
// seg7_display_controller: time-multiplexed 8-digit common-anode 7-seg scan.
// Double-buffered display word, commits at frame wrap; registered outputs.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   enable      1 = scan, 0 = dark and held at digit 0
//   load        strobe, captures data into staging
//   data[31:0]  display word, nibble i on digit i (digit 0 rightmost)
//   dp_mask     decimal point request per digit (live)
//   blank_lz    leading-zero suppression
//   hex_out     nibble for external decoder
//   an          anode enables, active-low
//   dp          decimal point cathode, active-low
//   frame_done  one-cycle pulse on 7 -> 0 wrap
module seg7_display_controller #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    output logic [3:0]  hex_out,
    output logic [7:0]  an,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [19:0] DIV_LAST = 20'(REFRESH_DIV - 1);

    logic [19:0] div_cnt;
    logic [19:0] div_cnt_n;
    logic [2:0]  idx;
    logic [2:0]  idx_n;
    logic [31:0] staging;
    logic [31:0] staging_n;
    logic [31:0] committed;
    logic [31:0] committed_n;
    logic        pending;
    logic        pending_n;

    logic        tick;
    logic        wrap;
    logic        commit;

    logic [7:0]  nz;
    logic [7:0]  above;
    logic [7:0]  blanked;

    logic [3:0]  hex_n;
    logic [7:0]  an_n;
    logic        dp_n;

    // Scan sequencing and double-buffer control
    always_comb begin
        tick   = enable && (div_cnt == DIV_LAST);
        wrap   = tick && (idx == 3'd7);
        // While disabled the buffer is transparent so committed tracks staging
        commit = !enable || wrap;

        div_cnt_n = div_cnt + 20'd1;
        if (!enable || tick) begin
            div_cnt_n = '0;
        end

        idx_n = idx;
        if (!enable) begin
            idx_n = '0;
        end else if (tick) begin
            idx_n = idx + 3'd1;
        end

        staging_n = load ? data : staging;

        // Using staging_n gives the same-cycle load bypass on a commit
        committed_n = commit ? staging_n : committed;

        pending_n = pending;
        if (commit) begin
            pending_n = 1'b0;
        end else if (load) begin
            pending_n = 1'b1;
        end
    end

    // Leading-zero detection on the word that will be displayed next
    always_comb begin
        nz      = '0;
        above   = '0;
        blanked = '0;
        for (int k = 0; k < 8; k++) begin
            nz[k] = |committed_n[4*k +: 4];
        end
        // above[k]: some digit at position k or higher is non-zero
        for (int k = 0; k < 8; k++) begin
            above[k] = |(nz >> k);
        end
        for (int k = 1; k < 8; k++) begin
            blanked[k] = blank_lz && !above[k];
        end
    end

    // Output decode from next-state digit index
    always_comb begin
        hex_n = committed_n[{idx_n, 2'b00} +: 4];
        an_n  = ~(8'b1 << idx_n);
        dp_n  = ~dp_mask[idx_n];
        if (blanked[idx_n]) begin
            an_n = 8'hFF;
            dp_n = 1'b1;
        end
        if (!enable) begin
            an_n = 8'hFF;
            dp_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt    <= '0;
            idx        <= '0;
            staging    <= '0;
            committed  <= '0;
            pending    <= 1'b0;
            hex_out    <= '0;
            an         <= 8'hFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= div_cnt_n;
            idx        <= idx_n;
            staging    <= staging_n;
            committed  <= committed_n;
            pending    <= pending_n;
            hex_out    <= hex_n;
            an         <= an_n;
            dp         <= dp_n;
            frame_done <= wrap;
        end
    end

endmodule
